ram_2p_be: RTL

Parametrised simple dual-port RAM and successor to the single-port 64-bit data memory. It has one write port and one read port, both usable in the same cycle, with per-byte write enables and an optional output register.
- After reset, a built-in clear sequencer zeroes every word, so software never reads stale data.
- It sits between the CPU load/store unit and the memory map, as the data or instruction store.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_clear_ctrl.sv | 46 ++++
 rtl/ram_2p_be.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and byte helpers for the byte-enabled dual-port RAM.
package ram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {CLEAR, RUN} clr_state_t;

  // One byte of a write-first merge: new byte where enabled, old byte elsewhere.
  function automatic logic [BYTE_W-1:0] byte_merge(input logic [BYTE_W-1:0] old_b,
                                                   input logic [BYTE_W-1:0] new_b,
                                                   input logic              be);
    return be ? new_b : old_b;
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_par(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address writing zero, then holds RUN.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH  = 8064,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state, nxt;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt    = state;
    ready  = 1'b0;
    clr_we = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt == LAST) nxt = RUN;
      end
      RUN:     ready = 1'b1;
      default: nxt = CLEAR;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/ram_2p_be.sv
// Simple dual-port RAM with byte enables, write-first collisions, self-clear
// after reset and optional output register. Define RAM_PARITY_EN for byte parity.
module ram_2p_be
  import ram_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 8064,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int OUT_REG = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                ready,
  output logic                parity_err
);

  localparam int              BYTES   = DATA_W / BYTE_W;
  localparam int              STAGES  = 1 + OUT_REG;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clear_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .clock    (clock),
    .reset_n  (reset_n),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic wr_act, rd_acc, rd_ok, col;
  assign wr_act = ready & wr_en & ({1'b0, wr_addr} < DEPTH_X);
  assign rd_acc = ready & rd_en;
  assign rd_ok  = rd_acc & ({1'b0, rd_addr} < DEPTH_X);
  assign col    = wr_act & rd_ok & (wr_addr == rd_addr);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (clr_we) mem[clr_addr] <= '0;
    else if (wr_act)
      for (int i = 0; i < BYTES; i++)
        if (wr_be[i]) mem[wr_addr][BYTE_W*i +: BYTE_W] <= wr_data[BYTE_W*i +: BYTE_W];
  end

  // Read path merges the in-flight write so collisions return write-first data.
  logic [BYTES-1:0][BYTE_W-1:0] old_w, rd_w;
  logic [DATA_W-1:0]            rd_word;
  logic                         rd_err;

  assign old_w = mem[rd_addr];

  for (genvar i = 0; i < BYTES; i++) begin : g_byte
    assign rd_w[i] = byte_merge(old_w[i], wr_data[BYTE_W*i +: BYTE_W], col & wr_be[i]);
  end

  assign rd_word = rd_ok ? rd_w : '0;

`ifdef RAM_PARITY_EN
  logic [BYTES-1:0] par_mem [DEPTH];
  logic [BYTES-1:0] old_p, rd_p, calc_p;

  always_ff @(posedge clock) begin
    if (clr_we) par_mem[clr_addr] <= '0;
    else if (wr_act)
      for (int i = 0; i < BYTES; i++)
        if (wr_be[i]) par_mem[wr_addr][i] <= byte_par(wr_data[BYTE_W*i +: BYTE_W]);
  end

  assign old_p = par_mem[rd_addr];

  for (genvar i = 0; i < BYTES; i++) begin : g_par
    assign rd_p[i]   = (col & wr_be[i]) ? byte_par(wr_data[BYTE_W*i +: BYTE_W]) : old_p[i];
    assign calc_p[i] = byte_par(rd_w[i]);
  end

  assign rd_err = rd_ok & (|(rd_p ^ calc_p));
`else
  assign rd_err = 1'b0;
`endif

  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1]             err_pipe;
  logic [STAGES:1][DATA_W-1:0] dat_pipe;

  // Data stages only load on a valid beat so rd_data holds between reads.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) begin
        dat_pipe[1] <= rd_word;
        err_pipe[1] <= rd_err;
      end
      for (int k = 2; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) begin
          dat_pipe[k] <= dat_pipe[k-1];
          err_pipe[k] <= err_pipe[k-1];
        end
      end
    end
  end

  assign rd_data    = dat_pipe[STAGES];
  assign rd_valid   = vld_pipe[STAGES];
  assign parity_err = vld_pipe[STAGES] & err_pipe[STAGES];

endmodule
